// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared combinational ALU.
// Round-robin grant, registered ALU drive, op-dependent hold, tagged response.
module alu_scheduler #(
  parameter int MULDIV_CYCLES = 4,
  parameter int BASE_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [1:0]  req_form,
  input  logic [3:0]  req_vec,
  input  logic [7:0]  req_logic_select,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [63:0] req_c,
  input  logic [63:0] req_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_y1,
  output logic [31:0] rsp_y2,
  output logic [2:0]  alu_op,
  output logic        alu_form,
  output logic [1:0]  alu_vec,
  output logic [3:0]  alu_logic_select,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_c,
  output logic [31:0] alu_d,
  input  logic [31:0] alu_y1,
  input  logic [31:0] alu_y2,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b101;
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);
  localparam logic [3:0] BS_LOAD = 4'(BASE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_y1_q, rsp_y1_d;
  logic [31:0] rsp_y2_q, rsp_y2_d;
  logic [2:0]  op_q, op_d;
  logic        form_q, form_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  ls_q, ls_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] c_q, c_d;
  logic [31:0] d_q, d_d;

  logic        gnt;
  logic        accept;
  logic [2:0]  sel_op;
  logic        is_muldiv;

  // A tie goes to whoever was not served last.
  always_comb begin
    gnt = 1'b0;
    unique case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant_q;
      default: gnt = 1'b0;
    endcase
  end

  assign accept    = (state_q == IDLE) && (|req_valid) && !rst;
  assign req_ready = accept ? {gnt, ~gnt} : 2'b00;
  assign sel_op    = gnt ? req_op[5:3] : req_op[2:0];
  assign is_muldiv = (sel_op == OP_MULT) || (sel_op == OP_DIV);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_id_d     = rsp_id_q;
    rsp_y1_d     = rsp_y1_q;
    rsp_y2_d     = rsp_y2_q;
    op_d         = op_q;
    form_d       = form_q;
    vec_d        = vec_q;
    ls_d         = ls_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = sel_op;
          form_d       = gnt ? req_form[1] : req_form[0];
          vec_d        = gnt ? req_vec[3:2] : req_vec[1:0];
          ls_d         = gnt ? req_logic_select[7:4]
                             : req_logic_select[3:0];
          a_d          = gnt ? req_a[63:32] : req_a[31:0];
          b_d          = gnt ? req_b[63:32] : req_b[31:0];
          c_d          = gnt ? req_c[63:32] : req_c[31:0];
          d_d          = gnt ? req_d[63:32] : req_d[31:0];
          rsp_id_d     = gnt;
          last_grant_d = gnt;
          cnt_d        = is_muldiv ? MD_LOAD : BS_LOAD;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_y1_d = alu_y1;
          rsp_y2_d = alu_y2;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      rsp_id_q     <= 1'b0;
      rsp_y1_q     <= 32'd0;
      rsp_y2_q     <= 32'd0;
      op_q         <= 3'd0;
      form_q       <= 1'b0;
      vec_q        <= 2'd0;
      ls_q         <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      c_q          <= 32'd0;
      d_q          <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y1_q     <= rsp_y1_d;
      rsp_y2_q     <= rsp_y2_d;
      op_q         <= op_d;
      form_q       <= form_d;
      vec_q        <= vec_d;
      ls_q         <= ls_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
    end
  end

  assign rsp_valid        = (state_q == DONE);
  assign rsp_id           = rsp_id_q;
  assign rsp_y1           = rsp_y1_q;
  assign rsp_y2           = rsp_y2_q;
  assign alu_op           = op_q;
  assign alu_form         = form_q;
  assign alu_vec          = vec_q;
  assign alu_logic_select = ls_q;
  assign alu_a            = a_q;
  assign alu_b            = b_q;
  assign alu_c            = c_q;
  assign alu_d            = d_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU.
// Table of single requests plus round-robin, backpressure and reset sequences.
module tb_alu_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [1:0]  req_form;
  logic [3:0]  req_vec;
  logic [7:0]  req_logic_select;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [63:0] req_c;
  logic [63:0] req_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_y1;
  logic [31:0] rsp_y2;
  logic [2:0]  alu_op;
  logic        alu_form;
  logic [1:0]  alu_vec;
  logic [3:0]  alu_logic_select;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic [31:0] alu_d;
  logic [31:0] alu_y1;
  logic [31:0] alu_y2;
  logic        busy;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b100;
  localparam logic [2:0] MULT = 3'b001;
  localparam logic [2:0] DIV  = 3'b101;
  localparam logic [2:0] LOGI = 3'b010;
  localparam logic [2:0] COPY = 3'b111;

  int checks = 0;
  int errors = 0;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_form(req_form), .req_vec(req_vec),
    .req_logic_select(req_logic_select),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y1(rsp_y1), .rsp_y2(rsp_y2),
    .alu_op(alu_op), .alu_form(alu_form), .alu_vec(alu_vec),
    .alu_logic_select(alu_logic_select),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .alu_y1(alu_y1), .alu_y2(alu_y2), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU; its function is arbitrary but fixed.
  always_comb begin
    alu_y1 = 32'd0;
    alu_y2 = 32'd0;
    case (alu_op)
      ADD: begin
        if (alu_form) alu_y2 = alu_a + alu_b + alu_c;
        else          alu_y1 = alu_a + alu_b;
      end
      SUB: begin
        if (alu_form) alu_y2 = alu_a - alu_b - alu_c;
        else          alu_y1 = alu_a - alu_c;
      end
      MULT: begin
        alu_y1 = alu_a * alu_b;
        alu_y2 = alu_c * alu_d;
      end
      DIV: begin
        if (alu_b != 32'd0) begin
          alu_y1 = alu_a / alu_b;
          alu_y2 = alu_a % alu_b;
        end
      end
      default: begin
        alu_y1 = alu_a ^ alu_b;
        alu_y2 = alu_c | alu_d;
      end
    endcase
  end

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  ls;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] y1;
    logic [31:0] y2;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic set_req(input logic id, input logic [2:0] op,
                         input logic form, input logic [1:0] vec,
                         input logic [3:0] ls, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d);
    if (id) begin
      req_op[5:3]            = op;
      req_form[1]            = form;
      req_vec[3:2]           = vec;
      req_logic_select[7:4]  = ls;
      req_a[63:32]           = a;
      req_b[63:32]           = b;
      req_c[63:32]           = c;
      req_d[63:32]           = d;
      req_valid[1]           = 1'b1;
    end else begin
      req_op[2:0]            = op;
      req_form[0]            = form;
      req_vec[1:0]           = vec;
      req_logic_select[3:0]  = ls;
      req_a[31:0]            = a;
      req_b[31:0]            = b;
      req_c[31:0]            = c;
      req_d[31:0]            = d;
      req_valid[0]           = 1'b1;
    end
  endtask

  task automatic wait_rsp(input string name);
    int w;
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk(name, 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   ng;
    int   nr;
    int   cyc;
    int   gcyc;

    tbl[0] = '{1'b0, ADD,  1'b1, 2'd2, 4'h0, 32'd1, 32'd2, 32'd3,
               32'd2, 32'd0, 32'd6, 1};
    tbl[1] = '{1'b1, SUB,  1'b0, 2'd2, 4'h0, 32'd1, 32'd2, 32'd3,
               32'd2, 32'hFFFFFFFE, 32'd0, 1};
    tbl[2] = '{1'b0, MULT, 1'b0, 2'd1, 4'h3, 32'd7, 32'd6, 32'd3,
               32'd5, 32'd42, 32'd15, 4};
    tbl[3] = '{1'b1, DIV,  1'b1, 2'd3, 4'h5, 32'd100, 32'd7, 32'd0,
               32'd9, 32'd14, 32'd2, 4};
    tbl[4] = '{1'b0, LOGI, 1'b0, 2'd0, 4'hA, 32'hF0F0F0F0,
               32'hFF00FF00, 32'd1, 32'd2, 32'h0FF00FF0, 32'd3, 1};
    tbl[5] = '{1'b1, COPY, 1'b1, 2'd1, 4'hC, 32'hDEADBEEF, 32'd0,
               32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 1};

    rst = 1'b1;
    req_valid = 2'b00;
    req_op = '0;
    req_form = '0;
    req_vec = '0;
    req_logic_select = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    rsp_ready = 1'b1;

    // Reset: ready must stay low even with requests present.
    @(negedge clk);
    set_req(1'b0, ADD, 1'b0, 2'd0, 4'h0, 32'd1, 32'd1, 32'd0, 32'd0);
    set_req(1'b1, ADD, 1'b0, 2'd0, 4'h0, 32'd1, 32'd1, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp", {31'd0, rsp_id, rsp_y1 | rsp_y2}, 64'd0);
    chk("rst_alu", {alu_op, alu_form, alu_vec, alu_logic_select, alu_a},
        64'd0);
    chk("rst_alu_bcd", 64'(alu_b | alu_c | alu_d), 64'd0);

    // Table of single requests.
    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      @(negedge clk);
      set_req(v.id, v.op, v.form, v.vec, v.ls, v.a, v.b, v.c, v.d);
      #1;
      chk("req_ready", 64'(req_ready), v.id ? 64'd2 : 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        chk("alu_hold",
            {alu_op, alu_form, alu_vec, alu_logic_select, alu_a},
            {v.op, v.form, v.vec, v.ls, v.a});
        @(negedge clk);
        lat++;
      end
      chk("latency", 64'(lat), 64'(v.lat));
      chk("rsp_id", 64'(rsp_id), 64'(v.id));
      chk("rsp_y1", 64'(rsp_y1), 64'(v.y1));
      chk("rsp_y2", 64'(rsp_y2), 64'(v.y2));
      chk("alu_bcd", {alu_b, alu_d}, {v.b, v.d});
      @(negedge clk);
      chk("post_busy", {63'd0, busy | rsp_valid}, 64'd0);
    end

    // Both requesters valid: expect 0,1,0,1 every 3 cycles.
    set_req(1'b0, ADD, 1'b0, 2'd0, 4'h0, 32'd10, 32'd1, 32'd0, 32'd0);
    set_req(1'b1, ADD, 1'b0, 2'd0, 4'h0, 32'd20, 32'd2, 32'd0, 32'd0);
    ng = 0;
    nr = 0;
    cyc = 0;
    gcyc = 0;
    while ((ng < 4 || nr < 4) && cyc < 60) begin
      #1;
      if (rsp_valid) begin
        chk("rr_rsp_id", 64'(rsp_id), 64'(nr[0]));
        chk("rr_rsp_y1", 64'(rsp_y1), nr[0] ? 64'd22 : 64'd11);
        nr++;
      end
      if (req_ready != 2'b00 && ng < 4) begin
        chk("rr_grant", 64'(req_ready), ng[0] ? 64'd2 : 64'd1);
        if (ng > 0) chk("rr_period", 64'(cyc - gcyc), 64'd3);
        gcyc = cyc;
        ng++;
      end
      @(negedge clk);
      cyc++;
      if (ng == 4) req_valid = 2'b00;
    end
    chk("rr_count", 64'(ng + nr), 64'd8);

    // Backpressure in DONE with req1 waiting.
    rsp_ready = 1'b0;
    set_req(1'b0, ADD, 1'b0, 2'd0, 4'h0, 32'd5, 32'd6, 32'd0, 32'd0);
    #1;
    chk("bp_grant0", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("bp_rsp_valid");
    set_req(1'b1, SUB, 1'b0, 2'd0, 4'h0, 32'd9, 32'd0, 32'd4, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_y2, rsp_y1[29:0]},
          {1'b1, 1'b0, 32'd0, 30'd11});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_done", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("bp_grant1", 64'(req_ready), 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("bp_rsp1_valid");
    chk("bp_rsp1", {rsp_id, rsp_y1}, {1'b1, 32'd5});
    @(negedge clk);

    // Reset during the second EXEC cycle of a DIV.
    set_req(1'b0, DIV, 1'b0, 2'd0, 4'h0, 32'd100, 32'd7, 32'd0, 32'd0);
    #1;
    chk("rd_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rd_busy", 64'(busy), 64'd0);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rd_alu_a", 64'(alu_a), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rd_no_rsp", 64'(rsp_valid), 64'd0);
    end
    set_req(1'b0, ADD, 1'b0, 2'd0, 4'h0, 32'd3, 32'd4, 32'd0, 32'd0);
    set_req(1'b1, ADD, 1'b0, 2'd0, 4'h0, 32'd8, 32'd8, 32'd0, 32'd0);
    #1;
    chk("rd_tie", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("rd_rsp_valid2");
    chk("rd_rsp", {rsp_id, rsp_y1}, {1'b0, 32'd7});
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
